// File: rtl/ifetch_bus_pkg.sv
// Shared types for the instruction-fetch bus between the fetch stage and
// the instruction memory responder.
//   ifetch_req_t : request bundle driven by the fetch stage (req, byte addr)
//   ifetch_rsp_t : response bundle returned to the fetch stage
//   WORD_BYTES   : bytes per instruction word
package ifetch_bus_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } ifetch_req_t;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } ifetch_rsp_t;

endpackage

// File: rtl/resp_delay_pipe.sv
// Fixed-latency valid+payload shift pipeline used to return fetch responses.
// Only the valid bits are reset; payload registers load when the stage
// feeding them is valid, so the last stage keeps its last delivered payload.
//   clk, rstn  : clock, async active-low reset
//   in_valid   : new entry enters stage 0 at the edge
//   in_data    : payload of the new entry
//   out_valid  : last stage holds a valid entry this cycle
//   out_data   : payload of the last stage
module resp_delay_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 33
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) dat_q[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) begin
      if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction RAM answering the fetch bus with fixed-latency, in-order,
// pipelined responses and a bounded number of outstanding requests.
// A side load port writes words into the RAM at any time.
//   clk, rstn       : clock, async active-low reset (RAM contents survive)
//   instr_req_i     : fetch request
//   instr_gnt_o     : request accepted this cycle (combinational)
//   instr_addr_i    : fetch byte address, bits [1:0] ignored
//   instr_rdata_o   : returned word, held while rvalid is low
//   instr_rvalid_o  : response valid
//   instr_err_o     : response is an out-of-range error
//   gnt_stall_i     : forces gnt low
//   load_we_i       : side load write strobe
//   load_addr_i     : side load byte address
//   load_wdata_i    : side load data
module instr_mem_responder
  import ifetch_bus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 1,
  parameter int          MAX_OUTST = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = 33;
  // 33-bit end address so a window touching the top of the map cannot wrap.
  localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(MEM_WORDS * WORD_BYTES);

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < ADDR_END);
  endfunction

  ifetch_req_t     fetch;
  ifetch_rsp_t     rsp;
  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     fetch_off, load_off;
  logic [AW-1:0]   fetch_idx, load_idx;
  logic            fetch_err;
  logic            gnt, accept;
  logic [PW-1:0]   pipe_in, pipe_out;
  logic            pipe_vld;
  logic [CW-1:0]   outst_q;
  logic            have_rsp_q;
  logic            unused_addr_bits;

  assign fetch.req  = instr_req_i;
  assign fetch.addr = instr_addr_i;

  assign fetch_off = fetch.addr - BASE_ADDR;
  assign load_off  = load_addr_i - BASE_ADDR;
  assign fetch_idx = fetch_off[AW+1:2];
  assign load_idx  = load_off[AW+1:2];
  assign fetch_err = ~in_range(fetch.addr);
  assign unused_addr_bits = ^{fetch_off[31:AW+2], fetch_off[1:0],
                              load_off[31:AW+2], load_off[1:0]};

  // A response leaving the pipe this cycle frees a slot, so a full
  // responder can still grant in the same cycle.
  assign gnt    = rstn & fetch.req & ~gnt_stall_i &
                  ((outst_q < CW'(MAX_OUTST)) | pipe_vld);
  assign accept = fetch.req & gnt;

  // RAM is read at the grant edge; a load to the same word at that edge
  // lands afterwards, so the fetch sees the old contents.
  assign pipe_in = fetch_err ? {1'b1, 32'h0} : {1'b0, mem[fetch_idx]};

  always_ff @(posedge clk) begin
    if (load_we_i && in_range(load_addr_i)) mem[load_idx] <= load_wdata_i;
  end

  resp_delay_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (PW)
  ) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (accept),
    .in_data   (pipe_in),
    .out_valid (pipe_vld),
    .out_data  (pipe_out)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_q    <= '0;
      have_rsp_q <= 1'b0;
    end else begin
      if (pipe_vld) have_rsp_q <= 1'b1;
      case ({accept, pipe_vld})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Until the first response after reset the pipe payload is stale, so
  // rdata reads as zero.
  assign rsp.rvalid = pipe_vld;
  assign rsp.err    = pipe_vld & pipe_out[32];
  assign rsp.rdata  = (pipe_vld | have_rsp_q) ? pipe_out[31:0] : 32'h0;

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rsp.rvalid;
  assign instr_err_o    = rsp.err;
  assign instr_rdata_o  = rsp.rdata;

endmodule
